data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 43 ++++
 rtl/data_sram_resp_ram.sv | 34 +++
 rtl/data_sram_resp.sv | 121 ++++++++++++
 tb/tb_data_sram_resp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for data_sram_resp: register region tag, register offsets,
// default RAM depth and the register-select decode.
package data_sram_resp_pkg;

    localparam int unsigned RAM_AW_DEFAULT = 10;

    localparam logic [15:0] REG_REGION  = 16'hBFAF;
    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_TIMER   = 16'hE000;
    localparam logic [15:0] OFF_COMPARE = 16'hE004;
    localparam logic [15:0] OFF_STATUS  = 16'hE008;

    typedef enum logic [2:0] {
        RegNone,
        RegLed,
        RegTimer,
        RegCompare,
        RegStatus
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [15:0] off);
        case (off)
            OFF_LED:     return RegLed;
            OFF_TIMER:   return RegTimer;
            OFF_COMPARE: return RegCompare;
            OFF_STATUS:  return RegStatus;
            default:     return RegNone;
        endcase
    endfunction

    // Replace only the byte lanes selected by be.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_resp_ram.sv
// resp_ram: byte-enabled single-port synchronous RAM with a registered read port.
// Contents are never reset; only the read register is.
module resp_ram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          en,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read data only moves on a read, so writes leave the last read value visible.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= 32'd0;
        end else if (en && (wen == 4'b0000)) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: RAM plus a small register window (LED, optional timer block).
// Timer/compare/status exist only when DATA_SRAM_RESP_TIMER_EN is defined.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int unsigned RAM_AW = RAM_AW_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic        timer_irq
);

    logic        is_reg;
    logic        rd_acc;
    logic        wr_reg;
    reg_sel_e    sel;
    logic [31:0] ram_rdata;
    logic [31:0] reg_rdata;
    logic [31:0] reg_rdata_q;
    logic        rsel_q;
    logic [15:0] led_q;
    logic [31:0] timer_rd;
    logic [31:0] compare_rd;
    logic        status_rd;

    assign is_reg = (data_sram_addr[31:16] == REG_REGION);
    assign sel    = decode_reg(data_sram_addr[15:0]);
    assign rd_acc = data_sram_en && (data_sram_wen == 4'b0000);
    assign wr_reg = data_sram_en && (data_sram_wen != 4'b0000) && is_reg;

    resp_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .en     (data_sram_en && !is_reg),
        .wen    (data_sram_wen),
        .addr   (data_sram_addr[RAM_AW+1:2]),
        .wdata  (data_sram_wdata),
        .rdata  (ram_rdata)
    );

    always_comb begin
        reg_rdata = 32'd0;
        case (sel)
            RegLed:     reg_rdata = {16'd0, led_q};
            RegTimer:   reg_rdata = timer_rd;
            RegCompare: reg_rdata = compare_rd;
            RegStatus:  reg_rdata = {31'd0, status_rd};
            default:    reg_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q       <= 16'd0;
            rsel_q      <= 1'b0;
            reg_rdata_q <= 32'd0;
        end else begin
            if (wr_reg && (sel == RegLed)) begin
                if (data_sram_wen[0]) led_q[7:0]  <= data_sram_wdata[7:0];
                if (data_sram_wen[1]) led_q[15:8] <= data_sram_wdata[15:8];
            end
            if (rd_acc) begin
                rsel_q <= is_reg;
                if (is_reg) reg_rdata_q <= reg_rdata;
            end
        end
    end

`ifdef DATA_SRAM_RESP_TIMER_EN
    logic [31:0] timer_q;
    logic [31:0] compare_q;
    logic        status_q;
    logic        match;

    // Match uses the pre-increment timer value.
    assign match = (compare_q != 32'd0) && (timer_q == compare_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q   <= 32'd0;
            compare_q <= 32'd0;
            status_q  <= 1'b0;
        end else begin
            if (wr_reg && (sel == RegTimer)) begin
                timer_q <= merge_lanes(timer_q, data_sram_wdata, data_sram_wen);
            end else begin
                timer_q <= timer_q + 32'd1;
            end
            if (wr_reg && (sel == RegCompare)) begin
                compare_q <= merge_lanes(compare_q, data_sram_wdata, data_sram_wen);
            end
            if (match) begin
                status_q <= 1'b1;
            end else if (wr_reg && (sel == RegStatus) && data_sram_wen[0] && data_sram_wdata[0]) begin
                status_q <= 1'b0;
            end
        end
    end

    assign timer_rd   = timer_q;
    assign compare_rd = compare_q;
    assign status_rd  = status_q;
`else
    assign timer_rd   = 32'd0;
    assign compare_rd = 32'd0;
    assign status_rd  = 1'b0;
`endif

    assign data_sram_rdata = rsel_q ? reg_rdata_q : ram_rdata;
    assign led             = led_q;
    assign timer_irq       = status_rd;

endmodule

// File: tb/tb_data_sram_resp.sv
// Randomized self-checking bench for data_sram_resp against a behavioural model
// (word map for RAM, plain variables for the register window).
module tb_data_sram_resp;

    localparam int RAM_AW = 10;
`ifdef DATA_SRAM_RESP_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic        irq;

    data_sram_resp #(
        .RAM_AW (RAM_AW)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .timer_irq       (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem [int];
    logic [31:0] m_rdata;
    logic [15:0] m_led;
    logic [31:0] m_timer;
    logic [31:0] m_compare;
    logic        m_status;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_rdata   = 32'd0;
        m_led     = 16'd0;
        m_timer   = 32'd0;
        m_compare = 32'd0;
        m_status  = 1'b0;
    endtask

    function automatic logic [31:0] m_reg_read(input logic [15:0] off);
        case (off)
            16'hF000: return {16'd0, m_led};
            16'hE000: return TIMER_EN ? m_timer : 32'd0;
            16'hE004: return TIMER_EN ? m_compare : 32'd0;
            16'hE008: return TIMER_EN ? {31'd0, m_status} : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    // One rising edge of the reference behaviour, using pre-edge state throughout.
    task automatic model_step(input logic e, input logic [3:0] we, input logic [31:0] a,
                              input logic [31:0] d);
        logic        is_reg;
        logic        wr;
        logic        match;
        int          idx;
        logic [15:0] off;
        logic [31:0] old_w;
        logic [31:0] tmp;
        logic [31:0] n_timer;
        logic [31:0] n_compare;
        logic        n_status;
        is_reg = (a[31:16] == 16'hBFAF);
        off    = a[15:0];
        idx    = int'(a[RAM_AW+1:2]);
        wr     = e && (we != 4'd0);
        match  = (m_compare != 32'd0) && (m_timer == m_compare);
        if (e && we == 4'd0)
            m_rdata = is_reg ? m_reg_read(off) : (m_mem.exists(idx) ? m_mem[idx] : 32'd0);
        n_timer   = m_timer + 32'd1;
        n_compare = m_compare;
        n_status  = match ? 1'b1 : m_status;
        if (wr && is_reg) begin
            case (off)
                16'hF000: begin
                    tmp   = lanes({16'd0, m_led}, d, we);
                    m_led = tmp[15:0];
                end
                16'hE000: n_timer = lanes(m_timer, d, we);
                16'hE004: n_compare = lanes(m_compare, d, we);
                16'hE008: if (!match && we[0] && d[0]) n_status = 1'b0;
                default: ;
            endcase
        end else if (wr) begin
            old_w = m_mem.exists(idx) ? m_mem[idx] : 32'd0;
            m_mem[idx] = lanes(old_w, d, we);
        end
        if (TIMER_EN) begin
            m_timer   = n_timer;
            m_compare = n_compare;
            m_status  = n_status;
        end
    endtask

    task automatic cycle(input logic e, input logic [3:0] we, input logic [31:0] a,
                         input logic [31:0] d);
        en    = e;
        wen   = we;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_step(e, we, a, d);
        @(negedge clk);
        check("rdata", rdata, m_rdata);
        check("led", {16'd0, led}, {16'd0, m_led});
        check("irq", {31'd0, irq}, {31'd0, m_status});
    endtask

    function automatic logic [31:0] ram_addr(input int word);
        logic [31:0] a;
        a = $urandom;
        a[RAM_AW+1:2] = word[RAM_AW-1:0];
        if (a[31:16] == 16'hBFAF) a[31:16] = 16'h0000;
        return a;
    endfunction

    function automatic logic [31:0] reg_addr();
        logic [15:0] off;
        case ($urandom_range(0, 4))
            0: off = 16'hF000;
            1: off = 16'hE000;
            2: off = 16'hE004;
            3: off = 16'hE008;
            default: off = 16'h1230;
        endcase
        return {16'hBFAF, off};
    endfunction

    initial begin
        resetn = 1'b0;
        en     = 1'b0;
        wen    = 4'd0;
        addr   = 32'd0;
        wdata  = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_rdata", rdata, 32'd0);
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        resetn = 1'b1;

        // Access issued in the very first cycle after release.
        cycle(1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344);
        cycle(1'b1, 4'h0, 32'h0000_0010, 32'd0);
        check("wr_rd_full", rdata, 32'h1122_3344);
        cycle(1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD);
        check("rdata_hold_on_wr", rdata, 32'h1122_3344);
        cycle(1'b1, 4'h0, 32'h0000_0010, 32'd0);
        check("wr_rd_partial", rdata, 32'h11BB_33DD);
        cycle(1'b1, 4'hF, 32'hBFAF_F000, 32'h0000_BEEF);
        check("led_write", {16'd0, led}, 32'h0000_BEEF);
        cycle(1'b1, 4'h0, 32'hBFAF_F000, 32'd0);
        check("led_read", rdata, 32'h0000_BEEF);
        cycle(1'b0, 4'h0, 32'h0000_0010, 32'd0);
        check("rdata_hold_idle", rdata, 32'h0000_BEEF);

        for (int w = 16; w < 32; w++) cycle(1'b1, 4'hF, ram_addr(w), $urandom);

        for (int n = 0; n < 400; n++) begin
            logic        e;
            logic [3:0]  we;
            logic [31:0] a;
            e  = ($urandom_range(0, 7) != 0);
            we = ($urandom_range(0, 1) != 0) ? 4'(($urandom_range(1, 15))) : 4'd0;
            a  = ($urandom_range(0, 2) == 0) ? reg_addr() : ram_addr($urandom_range(16, 31));
            cycle(e, we, a, $urandom);
        end

        // Timer wrap and compare match.
        cycle(1'b1, 4'hF, 32'hBFAF_E004, 32'd0);
        cycle(1'b1, 4'h1, 32'hBFAF_E008, 32'd1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        cycle(1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
        cycle(1'b1, 4'hF, 32'hBFAF_E004, 32'h0000_0001);
        cycle(1'b1, 4'h0, 32'hBFAF_E000, 32'd0);
        check("timer_max", rdata, TIMER_EN ? 32'hFFFF_FFFF : 32'd0);
        cycle(1'b1, 4'h0, 32'hBFAF_E000, 32'd0);
        check("timer_wrap", rdata, 32'd0);
        check("irq_pre_match", {31'd0, irq}, 32'd0);
        cycle(1'b0, 4'h0, 32'd0, 32'd0);
        check("irq_match", {31'd0, irq}, {31'd0, TIMER_EN});

        // Clear racing a match: match wins, then a plain clear takes effect.
        cycle(1'b1, 4'hF, 32'hBFAF_E004, 32'h0000_0066);
        cycle(1'b1, 4'h1, 32'hBFAF_E008, 32'd1);
        check("irq_clear2", {31'd0, irq}, 32'd0);
        cycle(1'b1, 4'hF, 32'hBFAF_E000, 32'd100);
        cycle(1'b0, 4'h0, 32'd0, 32'd0);
        cycle(1'b0, 4'h0, 32'd0, 32'd0);
        cycle(1'b1, 4'h1, 32'hBFAF_E008, 32'd1);
        check("irq_match_wins", {31'd0, irq}, {31'd0, TIMER_EN});
        cycle(1'b1, 4'h1, 32'hBFAF_E008, 32'd1);
        check("irq_clear3", {31'd0, irq}, 32'd0);

        // Reset asserted mid-read.
        en    = 1'b1;
        wen   = 4'h0;
        addr  = 32'hBFAF_E000;
        wdata = 32'd0;
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_led", {16'd0, led}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        cycle(1'b1, 4'h0, 32'h0000_0010, 32'd0);
        check("ram_kept", rdata, 32'h11BB_33DD);
        cycle(1'b1, 4'h0, 32'hBFAF_E000, 32'd0);
        check("timer_after_rst", rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
